// File: rtl/axis_sample_buffer_if.sv
// AXI4-Stream handshake bundle: data, valid and ready for one stream direction.
interface axis_sample_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_sample_buffer.sv
// Sample buffer: absorbs a non-stallable input stream into RAM and presents it
// first-word-fall-through on an AXI4-Stream master port, with fill level and
// saturating drop counter. Read path is RAM registered read (mid stage) then
// the output register; occupancy counts RAM words, the mid stage and output.
module axis_sample_buffer #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  flush,
    axis_sample_buffer_if.slave   s_axis,
    axis_sample_buffer_if.master  m_axis,
    output logic [ADDR_WIDTH:0]   sts_count,
    output logic [CNTR_WIDTH-1:0] sts_overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

    logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];
    logic [AXIS_TDATA_WIDTH-1:0] ram_q;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_q;

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [ADDR_WIDTH:0]   ram_count;
    logic [CNTR_WIDTH-1:0] ovf_q;
    logic                  mid_valid_q;
    logic                  mid_valid_d;
    logic                  out_valid_q;
    logic                  out_valid_d;

    logic clear;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic out_load;
    logic rd_en;

    assign s_axis.tready = 1'b1;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign sts_count     = count_q;
    assign sts_overflow  = ovf_q;

    assign clear = areset | flush;

    // Handshake decode, RAM occupancy and read-pipeline advance conditions.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        pop       = out_valid_q & m_axis.tready;
        // Full plus a pop in the same cycle frees a slot, so the word is accepted.
        push      = s_axis.tvalid & ~clear & (~full | pop);
        drop      = s_axis.tvalid & ~clear & full & ~pop;
        // Words still in RAM that have not been issued to the read register.
        ram_count = count_q - {{ADDR_WIDTH{1'b0}}, mid_valid_q}
                            - {{ADDR_WIDTH{1'b0}}, out_valid_q};
        // Mid stage moves to the output whenever the output is empty or draining.
        out_load  = mid_valid_q & (~out_valid_q | pop);
        // Only issue a RAM read when the mid stage will be free to take it.
        rd_en     = (ram_count != '0) & (~mid_valid_q | out_load);

        mid_valid_d = mid_valid_q;
        if (rd_en) begin
            mid_valid_d = 1'b1;
        end else if (out_load) begin
            mid_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        if (out_load) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state: pointers, occupancy, drop counter and stage valids.
    always_ff @(posedge aclk) begin
        if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
            mid_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + 1'b1;
            end
            count_q     <= count_d;
            mid_valid_q <= mid_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Sample RAM write port; left unreset so it maps onto block RAM.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_axis.tdata;
        end
    end

    // Registered RAM read into the mid stage.
    always_ff @(posedge aclk) begin
        if (rd_en) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    // Output data register: cleared only by reset, otherwise held until reloaded.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data_q <= '0;
        end else if (out_load && !flush) begin
            out_data_q <= ram_q;
        end
    end

endmodule

// File: doc/axis_sample_buffer.md
# axis_sample_buffer

Stream buffer placed directly upstream of the AXI4-Lite stream reader. It absorbs a free-running, non-stallable sample stream (ADC or DSP output) into on-chip memory. It presents the buffered words first-word-fall-through on a master AXI4-Stream port, from which the CPU drains one word per AXI read. It also reports fill level and the number of words lost on overflow, so software can size its polling loop and detect gaps.

## Interface
- AXIS_TDATA_WIDTH, default 32: width of input and output data.
- ADDR_WIDTH, default 10: capacity is DEPTH = 2^ADDR_WIDTH words, counting the output register.
- CNTR_WIDTH, default 32: width of the overflow counter.

- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of the buffer contents and the overflow counter.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  constant 1; the source is never stalled.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  oldest buffered word.
- m_axis_tvalid  out  1  m_axis_tdata holds a valid word.
- m_axis_tready  in  1  consumer pops the word.
- sts_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- sts_overflow  out  CNTR_WIDTH  words dropped since the last reset or flush; saturates at all-ones.

## Operation
- Storage: dual-port RAM (inferred, registered read) plus one output register. Occupancy limit is DEPTH words total, including the output register.
- Write (push) when s_axis_tvalid=1, flush=0, and either occupancy < DEPTH or a pop happens in the same cycle. Full plus simultaneous pop therefore accepts the new word.
- Drop when s_axis_tvalid=1, flush=0, occupancy = DEPTH, and no pop in that cycle:
  - The word is discarded.
  - sts_overflow increments by 1, holding at 2^CNTR_WIDTH-1.
  - Buffer contents are unchanged.
- Pop when m_axis_tvalid=1 and m_axis_tready=1. The output register then reloads from RAM on the next edge if RAM is non-empty; otherwise m_axis_tvalid falls.
- Order is strict FIFO. Pointers are ADDR_WIDTH bits and wrap modulo DEPTH with no gap or duplicate.
- sts_count is registered and equals pushes minus pops since the last clear:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- flush = 1 for one or more cycles:
  - On the next edge, pointers, sts_count and sts_overflow are set to 0 and m_axis_tvalid to 0.
  - Any input word in that cycle is discarded and not counted as dropped.
  - A pop in that cycle is also discarded.
- areset has the same effect as flush, and additionally sets m_axis_tdata to 0.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, sts_count=0, sts_overflow=0, s_axis_tready=1.
- Fall-through latency into an empty buffer:
  - Word accepted at edge k.
  - m_axis_tvalid=1 with that word after edge k+2 (RAM write, then RAM read into the output register).
  - sts_count=1 after edge k.
- Sustained throughput: one push and one pop per cycle, indefinitely, once the output register is filled.
- Output stability: m_axis_tdata and m_axis_tvalid change only after a pop, a fill of an empty output register, flush, or reset. They are stable while m_axis_tvalid=1 and m_axis_tready=0.
- m_axis_tvalid never depends combinationally on m_axis_tready. The push-enable may depend combinationally on m_axis_tready (full plus pop case).
- Wrap-around: word DEPTH+1 is written to address 0 once address 0 has been popped. No bubble is allowed in the output stream at wrap.
- Mid-operation reset or flush: the next word accepted afterwards is the first word emitted. No stale word may appear on m_axis_tdata with m_axis_tvalid=1.

## Test plan
- Single word: after reset, push 0xA5A5_0001 at edge k with m_axis_tready=0 -> m_axis_tvalid=1 and tdata=0xA5A5_0001 after edge k+2; sts_count=1; word held until tready=1.
- Streaming: push 0..4999 continuously with m_axis_tready=1 every cycle, ADDR_WIDTH=4 -> output is 0..4999 in order with no gaps; sts_count ≤ 3 throughout; sts_overflow=0.
- Overflow: ADDR_WIDTH=4, tready=0, push 20 words -> sts_count=16, sts_overflow=4; draining yields words 0..15.
- Full plus pop: at sts_count=16, pulse tready and tvalid together for 1 cycle -> the new word is accepted, sts_count stays 16, sts_overflow unchanged.
- Flush mid-stream: with sts_count=9 and sts_overflow=2, assert flush with tvalid=1 -> next edge gives sts_count=0, sts_overflow=0, m_axis_tvalid=0; the next pushed word 0x1234 is the first one output.
- Saturation: CNTR_WIDTH=3, full buffer, push 10 more words -> sts_overflow holds at 7.
